alarm_clock_fsm: RTL and testbench

Sequencing controller for the keypad entry path of the digital alarm clock. Watches the decoded keypad code, the TIME and ALARM buttons and the 1 Hz tick, and generates the one-cycle `shift` strobe that pushes a pressed digit into the four-digit key buffer. Also drives the display-select and load strobes that commit the buffered digits as new alarm or current time. Sits between the keypad decoder and the key buffer / alarm register / time counter.

---
 rtl/alarm_clock_fsm_if.sv | 24 ++
 rtl/alarm_clock_fsm.sv | 117 +++++++++++
 tb/tb_alarm_clock_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_fsm_if.sv
// Signal bundle between the keypad sequencer and its neighbours: keypad code,
// buttons and seconds tick in; shift, display-select and load strobes out.
interface alarm_clock_fsm_if;
  logic       one_second;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;

  // master drives the inputs and watches the strobes (keypad side / bench)
  modport master (
    output one_second, alarm_button, time_button, key,
    input  shift, show_new_time, show_a, load_new_a, load_new_c
  );

  modport slave (
    input  one_second, alarm_button, time_button, key,
    output shift, show_new_time, show_a, load_new_a, load_new_c
  );
endinterface

// File: rtl/alarm_clock_fsm.sv
// Keypad entry sequencer for the alarm clock: one shift per digit press,
// commit to alarm or time on button, abandon entry after an idle timeout.
module alarm_clock_fsm #(
  parameter logic [3:0]  NOKEY       = 4'd10,
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input logic              clock,
  input logic              reset,
  alarm_clock_fsm_if.slave bus
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] sec_cnt_reg;
  logic [3:0] sec_cnt_next;

  logic key_valid;
  logic timeout;
  logic counting;

  logic shift_dec;
  logic show_new_time_dec;
  logic show_a_dec;
  logic load_new_a_dec;
  logic load_new_c_dec;

  assign key_valid = (bus.key != NOKEY);
  assign timeout   = (sec_cnt_reg == TIMEOUT_CNT);
  assign counting  = (state_reg == KEY_WAITED) || (state_reg == KEY_ENTRY);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= SHOW_TIME;
      sec_cnt_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      sec_cnt_reg <= sec_cnt_next;
    end
  end

  always_comb begin
    state_next        = SHOW_TIME;
    shift_dec         = 1'b0;
    show_new_time_dec = 1'b0;
    show_a_dec        = 1'b0;
    load_new_a_dec    = 1'b0;
    load_new_c_dec    = 1'b0;

    case (state_reg)
      SHOW_TIME: begin
        if (bus.alarm_button)  state_next = SHOW_ALARM;
        else if (key_valid)    state_next = KEY_STORED;
        else                   state_next = SHOW_TIME;
      end
      KEY_STORED: begin
        shift_dec  = 1'b1;
        state_next = KEY_WAITED;
      end
      KEY_WAITED: begin
        show_new_time_dec = 1'b1;
        if (!key_valid)        state_next = KEY_ENTRY;
        else if (timeout)      state_next = SHOW_TIME;
        else                   state_next = KEY_WAITED;
      end
      KEY_ENTRY: begin
        show_new_time_dec = 1'b1;
        if (bus.alarm_button)     state_next = SET_ALARM_TIME;
        else if (bus.time_button) state_next = SET_CURRENT_TIME;
        else if (key_valid)       state_next = KEY_STORED;
        else if (timeout)         state_next = SHOW_TIME;
        else                      state_next = KEY_ENTRY;
      end
      SHOW_ALARM: begin
        show_a_dec = 1'b1;
        state_next = bus.alarm_button ? SHOW_ALARM : SHOW_TIME;
      end
      SET_ALARM_TIME: begin
        load_new_a_dec    = 1'b1;
        show_new_time_dec = 1'b1;
        state_next        = SHOW_TIME;
      end
      SET_CURRENT_TIME: begin
        load_new_c_dec    = 1'b1;
        show_new_time_dec = 1'b1;
        state_next        = SHOW_TIME;
      end
      default: state_next = SHOW_TIME;
    endcase

    // The idle window restarts at every accepted digit and survives the
    // WAITED->ENTRY hop, so it measures time since the last shift.
    sec_cnt_next = sec_cnt_reg;
    if ((state_next == KEY_STORED) || !counting)
      sec_cnt_next = 4'd0;
    else if (bus.one_second && !timeout)
      sec_cnt_next = sec_cnt_reg + 4'd1;
  end

  assign bus.shift         = shift_dec;
  assign bus.show_new_time = show_new_time_dec;
  assign bus.show_a        = show_a_dec;
  assign bus.load_new_a    = load_new_a_dec;
  assign bus.load_new_c    = load_new_c_dec;

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Bench for alarm_clock_fsm: directed scenarios plus random keypad/button
// traffic, checked each cycle against a behavioural model of the entry rules.
module tb_alarm_clock_fsm;

  localparam logic [3:0] NK  = 4'd10;
  localparam int         TMO = 10;

  // model activity names
  localparam int A_IDLE = 0, A_PUSH = 1, A_HELD = 2, A_ENTRY = 3,
                 A_VIEW = 4, A_COMMIT_A = 5, A_COMMIT_C = 6;

  logic clock;
  logic reset;
  alarm_clock_fsm_if bus ();

  alarm_clock_fsm #(.NOKEY(NK), .TIMEOUT_SEC(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_shift  = 0;
  int n_load_a = 0;
  int n_load_c = 0;
  int n_cycle  = 0;

  int act  = A_IDLE;  // what the user is doing right now
  int idle = 0;       // whole seconds since the last accepted digit

  function automatic bit digit(input logic [3:0] k);
    return k != NK;
  endfunction

  function automatic int next_act(input int a, input int s, input bit rst,
                                  input bit al, input bit tm, input logic [3:0] k);
    if (rst) return A_IDLE;
    case (a)
      A_IDLE:  return al ? A_VIEW : (digit(k) ? A_PUSH : A_IDLE);
      A_PUSH:  return A_HELD;
      A_HELD:  return !digit(k) ? A_ENTRY : ((s >= TMO) ? A_IDLE : A_HELD);
      A_ENTRY: begin
        if (al) return A_COMMIT_A;
        if (tm) return A_COMMIT_C;
        if (digit(k)) return A_PUSH;
        return (s >= TMO) ? A_IDLE : A_ENTRY;
      end
      A_VIEW:  return al ? A_VIEW : A_IDLE;
      default: return A_IDLE;
    endcase
  endfunction

  // expected {shift, show_new_time, show_a, load_new_a, load_new_c}
  function automatic logic [4:0] expect_out(input int a);
    logic [4:0] v;
    v[4] = (a == A_PUSH);
    v[3] = (a == A_HELD) || (a == A_ENTRY) || (a == A_COMMIT_A) || (a == A_COMMIT_C);
    v[2] = (a == A_VIEW);
    v[1] = (a == A_COMMIT_A);
    v[0] = (a == A_COMMIT_C);
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, n_cycle);
    end
  endtask

  // One clock: apply inputs, advance model and DUT, compare all outputs.
  task automatic cyc(input bit rst, input bit os, input bit al, input bit tm,
                     input logic [3:0] k);
    int         a_n;
    int         s_n;
    logic [4:0] got;
    logic [4:0] exp_v;
    reset            = rst;
    bus.one_second   = os;
    bus.alarm_button = al;
    bus.time_button  = tm;
    bus.key          = k;
    a_n = next_act(act, idle, rst, al, tm, k);
    if (rst || a_n == A_PUSH || !(act == A_HELD || act == A_ENTRY)) s_n = 0;
    else s_n = (os && idle < TMO) ? idle + 1 : idle;
    @(posedge clock);
    #1;
    act  = a_n;
    idle = s_n;
    n_cycle++;
    got   = {bus.shift, bus.show_new_time, bus.show_a, bus.load_new_a, bus.load_new_c};
    exp_v = expect_out(act);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL outputs: got %b, expected %b (cycle %0d)", got, exp_v, n_cycle);
    end
    n_checks++;
    if (int'(bus.shift) + int'(bus.show_a) + int'(bus.load_new_a) + int'(bus.load_new_c) > 1) begin
      n_fail++;
      $display("FAIL exclusive: got %b, expected at most one strobe (cycle %0d)", got, n_cycle);
    end
    if (bus.shift)      n_shift++;
    if (bus.load_new_a) n_load_a++;
    if (bus.load_new_c) n_load_c++;
  endtask

  task automatic press(input logic [3:0] k);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, k);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, NK);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, NK);
      cyc(0, 0, 0, 0, NK);
    end
  endtask

  initial begin
    logic [3:0] rk;
    int         hold;
    bit         ral;

    // reset with a key and ALARM applied
    cyc(1, 0, 1, 0, 4'd3);
    cyc(1, 0, 1, 0, 4'd3);
    check("reset_outputs", int'({bus.shift, bus.show_new_time, bus.show_a,
                                 bus.load_new_a, bus.load_new_c}), 0);
    cyc(0, 0, 1, 0, NK);
    check("reset_release_show_a", int'(bus.show_a), 1);
    cyc(0, 0, 0, 0, NK);
    cyc(0, 0, 0, 0, NK);

    // four digits then commit as alarm
    n_shift = 0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("digit_shift_count", n_shift, 4);
    check("digit_show_new_time", int'(bus.show_new_time), 1);
    n_load_a = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, NK);
    check("set_alarm_load_a_count", n_load_a, 1);
    check("set_alarm_then_show_a", int'(bus.show_a), 1);
    cyc(0, 0, 0, 0, NK);
    check("alarm_release_show_a", int'(bus.show_a), 0);
    cyc(0, 0, 0, 0, NK);

    // two digits then commit as current time
    n_load_a = 0; n_load_c = 0;
    press(4'd0); press(4'd9);
    cyc(0, 0, 0, 1, NK);
    cyc(0, 0, 0, 1, NK);
    check("set_time_load_c_count", n_load_c, 1);
    check("set_time_load_a_count", n_load_a, 0);
    check("set_time_back_idle", int'(bus.show_new_time), 0);
    cyc(0, 0, 0, 0, NK);

    // timeout: full window, then a restart by a digit after nine seconds
    n_load_a = 0; n_load_c = 0;
    press(4'd5);
    pulses(10);
    check("timeout_exit", int'(bus.show_new_time), 0);
    press(4'd6);
    pulses(9);
    check("timeout_nine_stays", int'(bus.show_new_time), 1);
    press(4'd7);
    pulses(9);
    check("timeout_restart_stays", int'(bus.show_new_time), 1);
    pulses(1);
    check("timeout_restart_exit", int'(bus.show_new_time), 0);
    check("timeout_no_load", n_load_a + n_load_c, 0);

    // held key: one shift, then timeout straight out of the release wait
    n_shift = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, (i >= 5 && i <= 16), 0, 0, 4'd7);
      if (i == 15) begin
        check("held_key_single_shift", n_shift, 1);
        check("held_key_timeout", int'(bus.show_new_time), 0);
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, NK);

    // randomized traffic
    rk = NK; hold = 0; ral = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        rk   = ($urandom_range(0, 9) < 6 || (c % 300) > 220) ? NK : 4'($urandom_range(0, 9));
        hold = $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) ral = ~ral;
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0,
          ral, $urandom_range(0, 19) == 0, rk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
